byte_data_mem: RTL
==================

// Module: byte_data_mem
// PURPOSE
//  Parametrised byte-addressable data memory for the MEM stage: byte/half/word loads and stores,
//  sign/zero-extended loads, req/rsp handshake with configurable wait states, and out-of-window
//  and misalignment error reporting. Self-clears its array after reset, so no reset fan-out into RAM.
// PARAMETERS
//  WORD_LEN     32    data/address width in bits (multiple of 8; the 4-lane logic fixes it at 32)
//  DEPTH_WORDS  256   number of words stored; power of two
//  BASE_ADDR    1024  first valid byte address; must be word-aligned
//  WAIT_STATES  0     extra cycles between request accept and response (0..7)
// PORTS
//  clk        in   1         clock, rising edge
//  rst        in   1         asynchronous reset, active-low
//  req_valid  in   1         request present
//  req_ready  out  1         block can accept a request this cycle
//  req_we     in   1         1 = store, 0 = load
//  req_size   in   2         00 byte, 01 half, 10 word, 11 illegal
//  req_sign   in   1         load sign-extends when 1, zero-extends when 0
//  req_addr   in   WORD_LEN  byte address
//  req_wdata  in   WORD_LEN  store data, right-justified (byte in [7:0], half in [15:0])
//  rsp_valid  out  1         one-cycle pulse; completes every accepted request, loads and stores
//  rsp_rdata  out  WORD_LEN  load result, extended; 0 for stores and errors
//  rsp_err    out  1         qualified by rsp_valid
//  busy       out  1         high while the clear sweep runs
// BEHAVIOUR
//  Reset (rst=0, async): state=CLEAR, clr_ptr=0; req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=1.
//  CLEAR: writes one zero word per cycle at clr_ptr; leaves after DEPTH_WORDS cycles -> IDLE, busy=0.
//    req_valid is ignored during CLEAR; nothing is accepted and no response is produced.
//  IDLE: req_ready=1. Accept = req_valid & req_ready at a rising edge -> WAIT (WAIT_STATES>0) or RESP.
//  WAIT: down-counter loaded with WAIT_STATES at accept; RESP when it reaches 1. req_ready=0.
//  RESP: rsp_valid=1 for exactly one cycle, then IDLE. req_ready=0 in RESP.
//    No back-to-back accept: the minimum issue interval is WAIT_STATES+2 cycles.
//  Latency: rsp_valid is high in cycle accept+1+WAIT_STATES.
//  Index = (req_addr-BASE_ADDR)>>2; lane = req_addr[1:0]. Big-endian: lane 0 = bits [31:24].
//  Store commits at the accept edge and writes only the addressed lanes; other bytes are untouched.
//  Load reads at the accept edge into a holding register; rdata is stable through WAIT/RESP.
//  Error when any of these holds:
//    req_size==11; half with addr[0]!=0; word with addr[1:0]!=0; addr<BASE_ADDR; addr>=BASE_ADDR+4*DEPTH_WORDS.
//    On error: no write, rsp_rdata=0, rsp_err=1, same latency as a legal access.
//  Window compare uses WORD_LEN+1-bit arithmetic, so BASE_ADDR+4*DEPTH_WORDS cannot wrap.
//  rsp_rdata/rsp_err return to 0 in the cycle after RESP.
//  rst asserted mid-transaction: the access is abandoned with no response; a store already
//    committed at its accept edge stays committed, and the clear sweep then erases it.
// STRUCTURE
//  Shared defines: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD) and FSM state codes CLEAR/IDLE/WAIT/RESP.
//  Sub-module byte_lane_ram: DEPTH_WORDS x 4 bytes, one write enable per byte, synchronous read,
//    no reset. The top level holds the FSM, clear pointer, wait counter, lane steering and extension.
// TESTING
//  1 Reset release -> busy=1 for exactly 256 cycles, req_ready=0 throughout; a load at 1024 then returns 0.
//  2 SW 0x11223344 @1024; LB sign=1 @1025 -> 0x00000022; LH @1026 -> 0x00003344;
//    LB sign=1 after SB 0x80 @1027 -> 0xFFFFFF80.
//  3 SH 0xBEEF @1030 over word 0xAAAAAAAA -> LW @1028 returns 0xAAAABEEF.
//  4 LW @1025, SH @1029, LW @1020, LW @2048, req_size=11
//    -> each gives rsp_err=1, rdata=0, and memory is unchanged.
//  5 WAIT_STATES=3: accept at cycle t -> rsp_valid at t+4 only; req_ready low for t+1..t+4.
//  6 rst pulsed low during WAIT after a load -> no rsp_valid, busy=1 again, full clear sweep repeats.

Source files
------------

// File: rtl/byte_data_mem_pkg.sv
// Shared encodings and lane helpers for the byte-addressable data memory.
// Lane 0 is the most significant byte of a word.
package byte_data_mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Byte enables; bit 3 drives bits [31:24], matching lane 0.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] m;
    m = 4'b0000;
    case (size)
      SZ_BYTE: m = 4'b1000 >> lane;
      SZ_HALF: m = lane[1] ? 4'b0011 : 4'b1100;
      SZ_WORD: m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic size_err(input logic [1:0] size, input logic [1:0] lane);
    logic e;
    e = 1'b0;
    case (size)
      SZ_HALF: e = lane[0];
      SZ_WORD: e = |lane;
      SZ_ILL:  e = 1'b1;
      default: e = 1'b0;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] word, input logic [1:0] size,
                                         input logic [1:0] lane, input logic sign);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    h = lane[1] ? word[15:0] : word[31:16];
    case (size)
      SZ_BYTE: r = {{24{sign & b[7]}}, b};
      SZ_HALF: r = {{16{sign & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/byte_data_mem_lane_ram.sv
// Word-organised RAM with one write enable per byte and a registered read port.
// The read register only loads on re, so it doubles as the load holding register.
module byte_lane_ram #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int unsigned l = 0; l < 4; l++) begin
      if (we[l]) mem[addr][8*l +: 8] <= wdata[8*l +: 8];
    end
    if (re) rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/byte_data_mem.sv
// MEM-stage data memory: byte/half/word access with req/rsp handshake, wait states,
// error reporting and a post-reset clear sweep of the array.
module byte_data_mem
  import byte_data_mem_pkg::*;
#(
  parameter int unsigned WORD_LEN    = 32,
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_sign,
  input  logic [WORD_LEN-1:0] req_addr,
  input  logic [WORD_LEN-1:0] req_wdata,
  output logic                rsp_valid,
  output logic [WORD_LEN-1:0] rsp_rdata,
  output logic                rsp_err,
  output logic                busy
);

  localparam int unsigned      AW       = $clog2(DEPTH_WORDS);
  localparam logic [WORD_LEN:0] BASE_W  = (WORD_LEN+1)'(BASE_ADDR);
  localparam logic [WORD_LEN:0] LIMIT_W = BASE_W + (WORD_LEN+1)'(4 * DEPTH_WORDS);
  localparam logic [AW-1:0]    BASE_IDX = BASE_W[AW+1:2];
  localparam logic [2:0]       WS       = 3'(WAIT_STATES);

  state_e        state_q;
  logic [AW-1:0] clr_q;
  logic [2:0]    cnt_q;
  logic [1:0]    lane_q;
  logic [1:0]    size_q;
  logic          sign_q;
  logic          err_q;
  logic          load_q;

  logic          accept;
  logic          in_win;
  logic          req_err;
  logic [AW-1:0] idx_d;
  logic [31:0]   wlanes_d;
  logic [3:0]    ram_we;
  logic          ram_re;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  assign accept  = req_valid & req_ready;
  assign in_win  = ({1'b0, req_addr} >= BASE_W) && ({1'b0, req_addr} < LIMIT_W);
  assign req_err = !in_win || size_err(req_size, req_addr[1:0]);
  // BASE_ADDR is word-aligned, so the low index bits subtract without a full-width adder.
  assign idx_d   = req_addr[AW+1:2] - BASE_IDX;

  always_comb begin
    wlanes_d = '0;
    case (req_size)
      SZ_BYTE: wlanes_d = {4{req_wdata[7:0]}};
      SZ_HALF: wlanes_d = {2{req_wdata[15:0]}};
      default: wlanes_d = req_wdata;
    endcase
  end

  always_comb begin
    ram_we    = '0;
    ram_re    = 1'b0;
    ram_addr  = idx_d;
    ram_wdata = wlanes_d;
    if (busy) begin
      ram_we    = '1;
      ram_addr  = clr_q;
      ram_wdata = '0;
    end else if (accept && !req_err) begin
      ram_we = req_we ? lane_mask(req_size, req_addr[1:0]) : 4'b0000;
      ram_re = !req_we;
    end
  end

  byte_lane_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .re   (ram_re),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_CLEAR;
      clr_q   <= '0;
      cnt_q   <= '0;
      lane_q  <= '0;
      size_q  <= '0;
      sign_q  <= 1'b0;
      err_q   <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          clr_q <= clr_q + 1'b1;
          if (clr_q == AW'(DEPTH_WORDS - 1)) state_q <= ST_IDLE;
        end
        ST_IDLE: begin
          if (accept) begin
            lane_q  <= req_addr[1:0];
            size_q  <= req_size;
            sign_q  <= req_sign;
            err_q   <= req_err;
            load_q  <= !req_we;
            cnt_q   <= WS;
            state_q <= (WS == 3'd0) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_q <= ST_RESP;
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_CLEAR;
      endcase
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign busy      = (state_q == ST_CLEAR);
  assign rsp_err   = rsp_valid & err_q;
  assign rsp_rdata = (rsp_valid && load_q && !err_q)
                     ? WORD_LEN'(extend(ram_rdata, size_q, lane_q, sign_q)) : '0;

endmodule
